// File: rtl/tl_ul_pkg.sv
// rtl/tl_ul_pkg.sv - TileLink-UL opcode constants and D-channel response record
package tl_ul_pkg;

    typedef enum logic [2:0] {
        PUT_FULL    = 3'd0,
        PUT_PARTIAL = 3'd1,
        ARITH       = 3'd2,
        LOGICAL     = 3'd3,
        GET         = 3'd4,
        INTENT      = 3'd5
    } a_opcode_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } d_opcode_e;

    // Source is parameter-sized, so it is registered beside this record.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [2:0]  size;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } d_rsp_t;

endpackage

// File: rtl/tl_ul_mem_array.sv
// rtl/tl_ul_mem_array.sv - word-organised scratch storage, byte write enables, combinational read
module tl_ul_mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tl_ul_mem_responder.sv
// rtl/tl_ul_mem_responder.sv - TL-UL scratchpad responder; TL_UL_MEM_RESPONDER_ERRLOG_EN adds a denial log
module tl_ul_mem_responder
    import tl_ul_pkg::*;
#(
    parameter int                ADDR_W      = 31,
    parameter int                SOURCE_W    = 3,
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 31'h0800_0000,
    parameter logic              SINK_ID     = 1'b0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [2:0]          a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [3:0]          a_mask,
    input  logic [31:0]         a_data,
    input  logic                a_corrupt,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [2:0]          d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic                d_sink,
    output logic                d_denied,
    output logic [31:0]         d_data,
    output logic                d_corrupt
`ifdef TL_UL_MEM_RESPONDER_ERRLOG_EN
    ,
    input  logic                err_clear,
    output logic                err_valid,
    output logic [ADDR_W-1:0]   err_addr
`endif
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int SPAN_W = IDX_W + 2;

    logic                a_fire;
    logic                d_fire;
    logic                hit;
    logic                aligned;
    logic                is_get;
    logic                is_put;
    logic                data_op;
    logic                req_ok;
    logic                mem_we;
    logic [IDX_W-1:0]    word_idx;
    logic [31:0]         rd_data;
    logic                d_valid_q;
    logic [SOURCE_W-1:0] source_q;
    d_rsp_t              rsp_d;
    d_rsp_t              rsp_q;
    logic                unused_param;

    assign unused_param = ^a_param;

    assign a_ready = !d_valid_q || d_ready;
    assign a_fire  = a_valid && a_ready;
    assign d_fire  = d_valid_q && d_ready;

    // BASE_ADDR is aligned to the window size, so a hit is an upper-bit match.
    assign hit      = (a_address[ADDR_W-1:SPAN_W] == BASE_ADDR[ADDR_W-1:SPAN_W]);
    assign word_idx = a_address[SPAN_W-1:2];

    always_comb begin
        aligned = 1'b0;
        case (a_size)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = !a_address[0];
            3'd2:    aligned = (a_address[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign is_get  = (a_opcode == GET);
    assign is_put  = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
    assign data_op = is_get || (a_opcode == ARITH) || (a_opcode == LOGICAL);
    assign req_ok  = hit && aligned && (is_get || is_put);
    assign mem_we  = a_fire && req_ok && is_put && !a_corrupt;

    // Data-bearing opcodes answer with AccessAckData even when refused.
    always_comb begin
        rsp_d         = '0;
        rsp_d.opcode  = data_op ? ACCESS_ACK_DATA : ACCESS_ACK;
        rsp_d.param   = 2'd0;
        rsp_d.size    = a_size;
        rsp_d.denied  = !req_ok;
        rsp_d.data    = (req_ok && is_get) ? rd_data : 32'd0;
        rsp_d.corrupt = !req_ok && data_op;
    end

    tl_ul_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (word_idx),
        .wstrb (a_mask),
        .wdata (a_data),
        .raddr (word_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_valid_q <= 1'b0;
            rsp_q     <= '0;
            source_q  <= '0;
        end else if (a_fire) begin
            d_valid_q <= 1'b1;
            rsp_q     <= rsp_d;
            source_q  <= a_source;
        end else if (d_fire) begin
            d_valid_q <= 1'b0;
        end
    end

    assign d_valid   = d_valid_q;
    assign d_opcode  = rsp_q.opcode;
    assign d_param   = rsp_q.param;
    assign d_size    = rsp_q.size;
    assign d_source  = source_q;
    assign d_sink    = SINK_ID;
    assign d_denied  = rsp_q.denied;
    assign d_data    = rsp_q.data;
    assign d_corrupt = rsp_q.corrupt;

`ifdef TL_UL_MEM_RESPONDER_ERRLOG_EN
    // A new denial outranks a same-cycle clear and recaptures the address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (a_fire && !req_ok) begin
            err_valid <= 1'b1;
            if (!err_valid || err_clear) begin
                err_addr <= a_address;
            end
        end else if (err_clear) begin
            err_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// tb/tb_tl_ul_mem_responder.sv - self-checking bench for tl_ul_mem_responder
module tb_tl_ul_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [30:0] BASE  = 31'h0800_0000;
    localparam logic [30:0] TOP   = BASE + 31'(4 * DEPTH);

    logic        clock, reset_n;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode, a_param, a_size, a_source;
    logic [30:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode, d_size, d_source;
    logic [1:0]  d_param;
    logic        d_sink, d_denied, d_corrupt;
    logic [31:0] d_data;
`ifdef TL_UL_MEM_RESPONDER_ERRLOG_EN
    logic        err_clear, err_valid;
    logic [30:0] err_addr;
    logic        m_err_v;
    logic [30:0] m_err_a;
`endif

    tl_ul_mem_responder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .a_corrupt (a_corrupt),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_sink    (d_sink),
        .d_denied  (d_denied),
        .d_data    (d_data),
        .d_corrupt (d_corrupt)
`ifdef TL_UL_MEM_RESPONDER_ERRLOG_EN
        ,
        .err_clear (err_clear),
        .err_valid (err_valid),
        .err_addr  (err_addr)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [2:0]  source;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] mmem[int];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_rsp   = 0;
    logic [2:0]  last_opcode, last_source;
    logic        last_denied, last_corrupt;
    logic [31:0] last_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response derived directly from the protocol rules, with a word-indexed memory.
    task automatic model_req(output bit ok);
        exp_t   e;
        longint a;
        bit     hit, aligned, legal;
        int     idx;
        logic [31:0] w;
        a       = longint'(a_address);
        hit     = (a >= longint'(BASE)) && (a < longint'(TOP));
        aligned = (a_size <= 3'd2) && ((a % (longint'(1) << a_size)) == 0);
        legal   = a_opcode inside {3'd0, 3'd1, 3'd4};
        ok      = hit && aligned && legal;
        idx     = int'((a - longint'(BASE)) / 4);
        e.opcode  = (a_opcode inside {3'd2, 3'd3, 3'd4}) ? 3'd1 : 3'd0;
        e.size    = a_size;
        e.source  = a_source;
        e.denied  = !ok;
        e.corrupt = !ok && (e.opcode == 3'd1);
        e.data    = 32'd0;
        if (ok && a_opcode == 3'd4) begin
            e.data = mmem.exists(idx) ? mmem[idx] : 32'd0;
        end
        if (ok && a_opcode inside {3'd0, 3'd1} && !a_corrupt) begin
            w = mmem.exists(idx) ? mmem[idx] : 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (a_mask[b]) w[8*b +: 8] = a_data[8*b +: 8];
            end
            mmem[idx] = w;
        end
        expq.push_back(e);
    endtask

    always @(negedge clock) begin
        bit ok;
        bit deny;
        deny = 1'b0;
        if (!reset_n) begin
`ifdef TL_UL_MEM_RESPONDER_ERRLOG_EN
            m_err_v = 1'b0;
            m_err_a = '0;
`endif
        end else begin
            chk("a_ready", a_ready, !d_valid || d_ready);
            chk("d_valid", d_valid, expq.size() > 0);
            if (d_valid && expq.size() > 0) begin
                chk("d_opcode", d_opcode, expq[0].opcode);
                chk("d_size", d_size, expq[0].size);
                chk("d_source", d_source, expq[0].source);
                chk("d_denied", d_denied, expq[0].denied);
                chk("d_data", d_data, expq[0].data);
                chk("d_corrupt", d_corrupt, expq[0].corrupt);
                chk("d_param", d_param, 2'd0);
                chk("d_sink", d_sink, 1'b0);
                if (d_ready) begin
                    last_opcode  = d_opcode;
                    last_source  = d_source;
                    last_denied  = d_denied;
                    last_corrupt = d_corrupt;
                    last_data    = d_data;
                    n_rsp++;
                    void'(expq.pop_front());
                end
            end
            if (a_valid && a_ready) begin
                model_req(ok);
                deny = !ok;
            end
`ifdef TL_UL_MEM_RESPONDER_ERRLOG_EN
            chk("err_valid", err_valid, m_err_v);
            chk("err_addr", err_addr, m_err_a);
            if (deny) begin
                if (!m_err_v || err_clear) m_err_a = a_address;
                m_err_v = 1'b1;
            end else if (err_clear) begin
                m_err_v = 1'b0;
            end
`endif
        end
    end

    task automatic send(input logic [2:0] op, input logic [2:0] size, input logic [30:0] addr,
                        input logic [3:0] mask, input logic [31:0] data, input logic [2:0] src,
                        input logic corrupt);
        bit fired;
        a_valid = 1'b1; a_opcode = op; a_size = size; a_address = addr;
        a_mask = mask; a_data = data; a_source = src; a_corrupt = corrupt;
        a_param = 3'd5;
        fired = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (a_ready) begin
                fired = 1'b1;
                break;
            end
        end
        if (!fired) chk("a_accept_timeout", 0, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            #1;
            if (expq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    task automatic get(input logic [30:0] addr, input logic [2:0] src);
        send(3'd4, 3'd2, addr, 4'hF, 32'd0, src, 1'b0);
    endtask

    task automatic put(input logic [30:0] addr, input logic [31:0] data, input logic [2:0] src);
        send(3'd0, 3'd2, addr, 4'hF, data, src, 1'b0);
    endtask

    task automatic chk_denied_data(input string name);
        chk({name, "_denied"}, last_denied, 1'b1);
        chk({name, "_corrupt"}, last_corrupt, 1'b1);
        chk({name, "_opcode"}, last_opcode, 3'd1);
        chk({name, "_data"}, last_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp0;
        reset_n = 1'b0; a_valid = 1'b0; d_ready = 1'b1;
        a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0;
`ifdef TL_UL_MEM_RESPONDER_ERRLOG_EN
        err_clear = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        chk("rst_d_valid", d_valid, 1'b0);
        chk("rst_d_opcode", d_opcode, 3'd0);
        chk("rst_d_data", d_data, 32'd0);
        chk("rst_d_denied", d_denied, 1'b0);
        chk("rst_d_corrupt", d_corrupt, 1'b0);
        chk("rst_d_source", d_source, 3'd0);
        chk("rst_d_sink", d_sink, 1'b0);
        chk("rst_a_ready", a_ready, 1'b1);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        put(BASE, 32'hDEADBEEF, 3'd5); idle(); drain();
        chk("putfull_opcode", last_opcode, 3'd0);
        chk("putfull_source", last_source, 3'd5);
        chk("putfull_denied", last_denied, 1'b0);
        get(BASE, 3'd2); idle(); drain();
        chk("get_data", last_data, 32'hDEADBEEF);
        chk("get_opcode", last_opcode, 3'd1);
        chk("get_denied", last_denied, 1'b0);

        put(BASE + 31'd4, 32'h11223344, 3'd1);
        send(3'd1, 3'd2, BASE + 31'd4, 4'b0010, 32'h0000AB00, 3'd1, 1'b0);
        get(BASE + 31'd4, 3'd1); idle(); drain();
        chk("partial_raw_data", last_data, 32'h1122AB44);

        put(BASE + 31'd12, 32'h0C0C0C0C, 3'd0); idle(); drain();
        rsp0 = n_rsp;
        fork
            begin
                get(BASE, 3'd1); get(BASE + 31'd4, 3'd2); get(BASE + 31'd12, 3'd3); idle();
            end
            begin
                d_ready = 1'b0;
                repeat (4) @(negedge clock);
                chk("stall_a_ready", a_ready, 1'b0);
                @(posedge clock);
                #1;
                d_ready = 1'b1;
            end
        join
        drain();
        chk("stall_rsp_count", n_rsp - rsp0, 3);
        chk("stall_last_source", last_source, 3'd3);
        chk("stall_last_data", last_data, 32'h0C0C0C0C);

        get(TOP, 3'd1); idle(); drain();
        chk_denied_data("oob_get");
        send(3'd4, 3'd2, BASE + 31'd2, 4'hF, 32'd0, 3'd2, 1'b0); idle(); drain();
        chk_denied_data("misalign_get");
        put(BASE - 31'd4, 32'h1, 3'd3); idle(); drain();
        chk("oob_put_opcode", last_opcode, 3'd0);
        chk("oob_put_denied", last_denied, 1'b1);
        chk("oob_put_corrupt", last_corrupt, 1'b0);
        send(3'd2, 3'd2, BASE, 4'hF, 32'd0, 3'd4, 1'b0);
        send(3'd5, 3'd2, BASE, 4'hF, 32'd0, 3'd5, 1'b0);
        send(3'd4, 3'd3, BASE, 4'hF, 32'd0, 3'd6, 1'b0);
        send(3'd0, 3'd1, BASE + 31'd1, 4'hF, 32'h99999999, 3'd7, 1'b0);
        get(BASE, 3'd0); idle(); drain();
        chk("no_write_on_deny", last_data, 32'hDEADBEEF);
        put(TOP - 31'd4, 32'h55AA55AA, 3'd1);
        get(TOP - 31'd4, 3'd1); idle(); drain();
        chk("last_word_data", last_data, 32'h55AA55AA);
        chk("last_word_denied", last_denied, 1'b0);

        put(BASE + 31'd8, 32'hCAFEF00D, 3'd2);
        send(3'd0, 3'd2, BASE + 31'd8, 4'hF, 32'h12345678, 3'd2, 1'b1); idle(); drain();
        chk("corrupt_put_denied", last_denied, 1'b0);
        get(BASE + 31'd8, 3'd2); idle(); drain();
        chk("corrupt_put_old_data", last_data, 32'hCAFEF00D);

        d_ready = 1'b0;
        get(BASE, 3'd4); idle();
        chk("pre_rst_d_valid", d_valid, 1'b1);
        #1 reset_n = 1'b0;
        #1 chk("async_rst_d_valid", d_valid, 1'b0);
        expq.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        d_ready = 1'b1;
        get(BASE, 3'd1); idle(); drain();
        chk("mem_kept_after_rst", last_data, 32'hDEADBEEF);

`ifdef TL_UL_MEM_RESPONDER_ERRLOG_EN
        get(TOP + 31'd16, 3'd1); idle(); drain();
        chk("errlog_first_valid", err_valid, 1'b1);
        chk("errlog_first_addr", err_addr, TOP + 31'd16);
        send(3'd4, 3'd2, BASE + 31'd2, 4'hF, 32'd0, 3'd1, 1'b0); idle(); drain();
        chk("errlog_hold_addr", err_addr, TOP + 31'd16);
        err_clear = 1'b1;
        @(posedge clock);
        #1;
        err_clear = 1'b0;
        chk("errlog_cleared", err_valid, 1'b0);
        err_clear = 1'b1;
        get(BASE - 31'd8, 3'd2); idle();
        err_clear = 1'b0;
        drain();
        chk("errlog_clear_vs_deny_valid", err_valid, 1'b1);
        chk("errlog_clear_vs_deny_addr", err_addr, BASE - 31'd8);
`endif

        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_ul_mem_responder.md
Name: tl_ul_mem_responder

Overview:
- TileLink-UL responder (slave) terminating the A/D channel pair that the core-side bundles carry as initiator.
- Accepts single-beat Get, PutFullData and PutPartialData into a local word-organised scratch memory, and returns AccessAck or AccessAckData on D.
- Sits behind the core's TL port as a tightly-coupled scratchpad; it is also the bench target for initiator-side passthrough checks.

Parameters:
- ADDR_W, 31, A-channel address width.
- SOURCE_W, 3, source ID width, echoed unchanged on D.
- DEPTH_WORDS, 1024, number of 32-bit words (power of two).
- BASE_ADDR, 31'h0800_0000, byte base address; must be aligned to DEPTH_WORDS*4.
- SINK_ID, 1'b0, constant driven on d_sink.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- a_valid / a_ready  in / out  1 / 1  A-channel handshake.
- a_opcode, a_param, a_size  in  3 each  TL opcode, param, log2 bytes.
- a_source  in  SOURCE_W  request ID.
- a_address  in  ADDR_W  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- a_corrupt  in  1  write data poisoned.
- d_valid / d_ready  out / in  1 / 1  D-channel handshake.
- d_opcode  out  3  0 = AccessAck, 1 = AccessAckData.
- d_param  out  2  always 0.
- d_size  out  3  echoes a_size.
- d_source  out  SOURCE_W  echoes a_source.
- d_sink  out  1  SINK_ID.
- d_denied  out  1  request refused.
- d_data  out  32  read data (0 for AccessAck or denied).
- d_corrupt  out  1  data invalid.

Behaviour:
- Reset: d_valid = 0; all D fields = 0 (d_sink = SINK_ID); memory contents are not reset.
- a_ready = !d_valid || d_ready. Combinational from d_ready only, never from a_valid.
- A fire = a_valid && a_ready. The response register loads on fire, so d_valid rises the next cycle (latency 1).
- Throughput: 1 request/cycle while d_ready is held high.
- If D fires and A fires in the same cycle, the register reloads and d_valid stays 1.
- If D fires without A, d_valid clears.
- D fields are held stable while d_valid && !d_ready.
- Decode at fire (opcodes: Get = 4, PutFull = 0, PutPartial = 1):
  - hit = address in [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
  - aligned = a_size <= 2 and the address is size-aligned.
  - ok = hit && aligned && opcode in {0, 1, 4}.
- Get, ok: d_opcode = 1, d_data = word at index (addr - BASE_ADDR) >> 2, sampled at fire. d_denied = 0, d_corrupt = 0.
- Put, ok: bytes with a_mask[i] = 1 are written at the fire edge, unless a_corrupt = 1, in which case no byte is written. d_opcode = 0, d_denied = 0.
- Any request not ok:
  - no memory write;
  - d_denied = 1;
  - d_opcode = 1 for Get, Arithmetic (2) and Logical (3); d_opcode = 0 for all others;
  - when d_opcode = 1, d_corrupt = 1; d_data = 0.
- Read-after-write: a Get firing the cycle after a Put to the same word returns the new data. There is no forwarding hazard, because the write commits at the Put's fire edge.
- a_param is ignored.
- Reset asserted mid-transaction: d_valid drops asynchronously and any pending response is lost. A Put already accepted stays committed.

Optional Feature:
- Macro: TL_UL_MEM_RESPONDER_ERRLOG_EN.
- With the macro, add three ports:
  - err_clear  in  1;
  - err_valid  out  1;
  - err_addr  out  ADDR_W.
- The first denied request at fire sets err_valid = 1 and captures a_address into err_addr. Later denials do not overwrite it while err_valid = 1.
- err_clear clears err_valid. If err_clear coincides with a new denial, the new denial wins: err_valid stays 1 and the new address is captured.
- Reset: err_valid = 0, err_addr = 0.
- Without the macro, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package tl_ul_pkg holds:
  - A opcode constants (PUT_FULL = 0, PUT_PARTIAL = 1, ARITH = 2, LOGICAL = 3, GET = 4, INTENT = 5);
  - D opcode constants (ACCESS_ACK = 0, ACCESS_ACK_DATA = 1);
  - a packed D-response struct typedef.
- One sub-module, tl_ul_mem_array: DEPTH_WORDS x 32 storage with byte write enables and combinational read.
- Decode and the response register stay in the top module.

Test Plan:
- PutFull addr = BASE, mask = F, data = 32'hDEADBEEF, source = 5, then Get same addr -> AccessAck (src 5), then AccessAckData data = DEADBEEF, denied = 0, one cycle after each fire.
- PutPartial addr = BASE + 4, mask = 4'b0010, data = 32'h0000AB00 over a word holding 32'h11223344 -> Get returns 32'h1122AB44.
- Back-to-back Gets with d_ready = 0 for 3 cycles -> a_ready = 0, D fields unchanged; d_ready = 1 -> one response per cycle, no loss or reorder.
- Get addr = BASE + 4*DEPTH_WORDS, and Get size = 2 at addr BASE + 2 -> denied = 1, corrupt = 1, opcode = 1, data = 0.
- PutFull with a_corrupt = 1 to BASE + 8 -> AccessAck denied = 0; later Get returns the old data.
- Reset pulse with d_valid = 1 -> d_valid = 0 immediately. With the macro: a denial latches err_addr; a second denial does not overwrite it; err_clear clears err_valid.
